// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial arithmetic units (adder / subtractor).
//   - state_t              : three-state sequencing used by the serial units
//   - SERIAL_WIDTH_DEFAULT : default operand width shared by the serial units
//   - cnt_width()          : width of a bit counter that counts 0..w-1
// -----------------------------------------------------------------------------
package serial_arith_pkg;

   // Sequencing states of a bit-serial unit.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Default operand / result width of the serial arithmetic units.
   localparam int SERIAL_WIDTH_DEFAULT = 8;

   // Counter width able to hold 0..w-1. Clamped to at least one bit so that
   // the smallest legal width (2) still yields a usable counter.
   function automatic int cnt_width(input int w);
      if (w <= 2) begin
         return 1;
      end
      return $clog2(w);
   endfunction

endpackage : serial_arith_pkg

// File: rtl/full_subtractor_1bit.sv
// -----------------------------------------------------------------------------
// full_subtractor_1bit
// One-bit full subtractor: computes a - b - bin.
// Ports:
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow in from the less significant bit
//   d    out 1  difference bit
//   bout out 1  borrow out to the more significant bit
// Purely combinational.
// -----------------------------------------------------------------------------
module full_subtractor_1bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // A borrow is produced when b exceeds a, or when a == b and a borrow is
   // already pending from the lower bit.
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor_1bit

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial two's-complement subtractor, DIFF = A - B (mod 2^WIDTH).
// Operands are captured in parallel on an accepted start, then processed LSB
// first, one bit per clock, through a single full subtractor with a
// registered borrow. The result is presented in parallel with borrow and
// signed-overflow flags and a one-cycle done pulse.
//
// Parameters:
//   WIDTH       operand / result width, legal range 2..32
// Ports:
//   clk         in   1      clock, rising edge
//   rst         in   1      synchronous active-high reset
//   start       in   1      operation request, sampled only while idle
//   a_data      in   WIDTH  minuend, captured on an accepted start
//   b_data      in   WIDTH  subtrahend, captured on an accepted start
//   busy        out  1      high while an operation is in flight (incl. done)
//   done        out  1      one-cycle pulse, diff and flags valid
//   diff        out  WIDTH  result register
//   borrow_out  out  1      final borrow out of the MSB (unsigned A < B)
//   overflow    out  1      signed overflow (borrow into MSB ^ borrow out)
//
// Timing: start accepted at edge E0, bits 0..WIDTH-1 processed at edges
// E1..E(WIDTH), done high during the cycle after E(WIDTH).
// -----------------------------------------------------------------------------
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_data,
   input  logic [WIDTH-1:0] b_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_t             state_q;
   logic [WIDTH-1:0]   shift_a_q;
   logic [WIDTH-1:0]   shift_b_q;
   logic [WIDTH-1:0]   diff_q;
   logic               borrow_q;
   logic [CNT_W-1:0]   bit_cnt_q;
   logic               borrow_out_q;
   logic               overflow_q;
   logic               busy_q;
   logic               done_q;

   // -------------------------------------------------------------------------
   // Datapath: one full subtractor on the current LSBs
   // -------------------------------------------------------------------------
   logic               d_bit;
   logic               bout_bit;
   logic [WIDTH-1:0]   diff_d;
   logic [WIDTH-1:0]   shift_a_d;
   logic [WIDTH-1:0]   shift_b_d;
   logic               last_bit;

   full_subtractor_1bit u_fsub (
      .a    (shift_a_q[0]),
      .b    (shift_b_q[0]),
      .bin  (borrow_q),
      .d    (d_bit),
      .bout (bout_bit)
   );

   // New difference bit enters at the MSB, so after WIDTH steps bit 0 of the
   // result has walked all the way down to diff[0].
   assign diff_d    = {d_bit, diff_q[WIDTH-1:1]};
   assign shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
   assign shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
   assign last_bit  = (bit_cnt_q == LAST_BIT);

   // -------------------------------------------------------------------------
   // FSM with registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         shift_a_q    <= '0;
         shift_b_q    <= '0;
         diff_q       <= '0;
         borrow_q     <= 1'b0;
         bit_cnt_q    <= '0;
         borrow_out_q <= 1'b0;
         overflow_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  shift_a_q <= a_data;
                  shift_b_q <= b_data;
                  diff_q    <= '0;
                  borrow_q  <= 1'b0;
                  bit_cnt_q <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= SHIFT;
               end
            end

            SHIFT: begin
               diff_q    <= diff_d;
               shift_a_q <= shift_a_d;
               shift_b_q <= shift_b_d;
               borrow_q  <= bout_bit;
               if (last_bit) begin
                  // MSB step: borrow_q still holds the borrow into the MSB,
                  // so overflow is the disagreement between borrow in/out.
                  borrow_out_q <= bout_bit;
                  overflow_q   <= borrow_q ^ bout_bit;
                  done_q       <= 1'b1;
                  state_q      <= DONE;
               end else begin
                  bit_cnt_q <= bit_cnt_q + CNT_W'(1);
               end
            end

            DONE: begin
               // The counter is left parked at WIDTH-1; it is reloaded on the
               // next accepted start.
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end

            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_out_q;
   assign overflow   = overflow_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start8, start16;
   logic [7:0]  a8, b8;
   logic [15:0] a16, b16;
   logic        busy8, done8, bo8, ov8;
   logic        busy16, done16, bo16, ov16;
   logic [7:0]  diff8;
   logic [15:0] diff16;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a_data(a8), .b_data(b8),
      .busy(busy8), .done(done8), .diff(diff8),
      .borrow_out(bo8), .overflow(ov8)
   );

   serial_subtractor #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .a_data(a16), .b_data(b16),
      .busy(busy16), .done(done16), .diff(diff16),
      .borrow_out(bo16), .overflow(ov16)
   );

   typedef struct {
      int          w;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] diff;
      logic        bo;
      logic        ov;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_diff(input int w);
      return (w == 16) ? {16'h0, diff16} : {24'h0, diff8};
   endfunction
   function automatic logic rd_done(input int w);
      return (w == 16) ? done16 : done8;
   endfunction
   function automatic logic rd_busy(input int w);
      return (w == 16) ? busy16 : busy8;
   endfunction
   function automatic logic rd_bo(input int w);
      return (w == 16) ? bo16 : bo8;
   endfunction
   function automatic logic rd_ov(input int w);
      return (w == 16) ? ov16 : ov8;
   endfunction

   // Reference: plain integer arithmetic on the operand values.
   function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] d, output logic bo, output logic ov);
      longint mask, sa, sb, sd, half;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      d    = 32'((longint'(a) - longint'(b)) & mask);
      bo   = (a < b);
      sa   = (longint'(a) >= half) ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb   = (longint'(b) >= half) ? longint'(b) - (longint'(1) << w) : longint'(b);
      sd   = sa - sb;
      ov   = (sd > half - 1) || (sd < -half);
   endfunction

   task automatic drive_start(input int w, input logic s, input logic [31:0] a, input logic [31:0] b);
      if (w == 16) begin
         start16 = s; a16 = a[15:0]; b16 = b[15:0];
      end else begin
         start8 = s; a8 = a[7:0]; b8 = b[7:0];
      end
   endtask

   // One full operation. Returns the result at the done cycle, the number of
   // cycles from acceptance to done (-1 on timeout), and whether busy stayed
   // high and the flags held their old values before the MSB step.
   task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output logic bo, output logic ov,
                         output int lat, output logic hold_ok);
      logic pbo, pov;
      int n;
      @(negedge clk);
      check("idle_before_start", {30'b0, rd_busy(w), rd_done(w)}, 32'd0);
      pbo = rd_bo(w);
      pov = rd_ov(w);
      drive_start(w, 1'b1, a, b);
      @(posedge clk);
      #1 drive_start(w, 1'b0, a, b);
      n = 0; hold_ok = 1'b1; lat = -1;
      while (n < 64) begin
         @(negedge clk);
         n++;
         if (!rd_busy(w)) hold_ok = 1'b0;
         if (rd_done(w)) break;
         if (n <= w && (rd_bo(w) !== pbo || rd_ov(w) !== pov)) hold_ok = 1'b0;
      end
      if (rd_done(w)) lat = n;
      d  = rd_diff(w);
      bo = rd_bo(w);
      ov = rd_ov(w);
   endtask

   task automatic op_and_check(input string tag, input int w, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ed, input logic ebo, input logic eov);
      logic [31:0] d;
      logic bo, ov, hold_ok;
      int lat;
      run_op(w, a, b, d, bo, ov, lat, hold_ok);
      check({tag, "_latency"}, lat, w + 1);
      check({tag, "_diff"}, d, ed);
      check({tag, "_borrow"}, {31'b0, bo}, {31'b0, ebo});
      check({tag, "_ovf"}, {31'b0, ov}, {31'b0, eov});
      check({tag, "_busy_flags_hold"}, {31'b0, hold_ok}, 32'd1);
      $display("op w=%0d a=0x%0h b=0x%0h -> diff=0x%0h bo=%0b ov=%0b lat=%0d", w, a, b, d, bo, ov, lat);
   endtask

   initial begin
      logic [31:0] ed, ra, rb;
      logic ebo, eov;
      int n, cnt;
      bit seen;

      vecs[0] = '{8,  32'h05,   32'h03,   32'h02,   1'b0, 1'b0};
      vecs[1] = '{8,  32'h03,   32'h05,   32'hFE,   1'b1, 1'b0};
      vecs[2] = '{8,  32'h80,   32'h01,   32'h7F,   1'b0, 1'b1};
      vecs[3] = '{8,  32'h7F,   32'hFF,   32'h80,   1'b1, 1'b1};
      vecs[4] = '{8,  32'hFF,   32'hFF,   32'h00,   1'b0, 1'b0};
      vecs[5] = '{16, 32'h0000, 32'h0001, 32'hFFFF, 1'b1, 1'b0};
      vecs[6] = '{16, 32'h8000, 32'h7FFF, 32'h0001, 1'b0, 1'b1};

      rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
      a8 = '0; b8 = '0; a16 = '0; b16 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_w8", {busy8, done8, bo8, ov8, diff8}, 12'h0);
      check("reset_w16", {busy16, done16, bo16, ov16, diff16}, 20'h0);

      // Table vectors, issued back-to-back (next start in the cycle after done).
      for (int i = 0; i < 7; i++) begin
         op_and_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].b,
                      vecs[i].diff, vecs[i].bo, vecs[i].ov);
      end

      // Start during SHIFT is ignored and not queued.
      @(negedge clk);
      drive_start(8, 1'b1, 32'h10, 32'h01);
      @(posedge clk);
      #1 drive_start(8, 1'b0, 32'h10, 32'h01);
      n = 0; seen = 0; cnt = 0;
      while (n < 40 && !seen) begin
         @(negedge clk);
         n++;
         if (n == 2) drive_start(8, 1'b1, 32'hFF, 32'h00);
         if (n == 3) drive_start(8, 1'b0, 32'h00, 32'h00);
         if (!busy8) cnt++;
         if (done8) seen = 1;
      end
      check("ignored_start_latency", seen ? n : -1, 9);
      check("ignored_start_diff", {24'h0, diff8}, 32'h0F);
      check("ignored_start_busy", cnt, 0);
      cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy8 || done8) cnt++;
      end
      check("ignored_start_not_queued", cnt, 0);
      $display("op ignored-start w=8 diff=0x%0h", diff8);

      // Leave borrow_out=1 so the mid-op reset clearing it is observable.
      op_and_check("pre_rst", 8, 32'h03, 32'h05, 32'hFE, 1'b1, 1'b0);

      // Reset mid-operation.
      @(negedge clk);
      drive_start(8, 1'b1, 32'hAA, 32'h55);
      @(posedge clk);
      #1 drive_start(8, 1'b0, 32'h00, 32'h00);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_clear", {busy8, done8, bo8, ov8, diff8}, 12'h0);
      cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8 || busy8) cnt++;
      end
      check("midrst_no_done", cnt, 0);
      $display("op mid-op reset w=8 diff=0x%0h busy=%0b", diff8, busy8);
      op_and_check("after_rst", 8, 32'h00, 32'h00, 32'h00, 1'b0, 1'b0);

      // rst and start together: rst wins.
      @(negedge clk);
      rst = 1'b1;
      drive_start(8, 1'b1, 32'h12, 32'h34);
      @(negedge clk);
      rst = 1'b0;
      drive_start(8, 1'b0, 32'h00, 32'h00);
      @(negedge clk);
      check("rst_beats_start", {30'b0, busy8, done8}, 32'd0);
      $display("op rst+start w=8 busy=%0b", busy8);

      // Randomized operations against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         int w;
         w  = (i % 2 == 1) ? 16 : 8;
         ra = $urandom & ((32'd1 << w) - 1);
         rb = $urandom & ((32'd1 << w) - 1);
         if (i % 10 == 4) rb = ra;
         model(w, ra, rb, ed, ebo, eov);
         op_and_check($sformatf("rand%0d", i), w, ra, rb, ed, ebo, eov);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor; the inverse-operation companion to the team's bit-serial adder.
- Loads two WIDTH-bit operands in parallel on a start pulse and computes DIFF = A - B, LSB first, one bit per clock through a 1-bit full subtractor with a registered borrow.
- Returns the difference in parallel, with a borrow flag, a signed-overflow flag and a one-cycle done pulse.
- Sits beside the serial adder in the arithmetic datapath as the area-cheap subtract unit.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a_data  input  WIDTH  minuend; captured on an accepted start.
- b_data  input  WIDTH  subtrahend; captured on an accepted start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; diff and flags are valid this cycle.
- diff  output  WIDTH  result register, A - B mod 2^WIDTH.
- borrow_out  output  1  final borrow from the MSB; 1 iff unsigned A < B.
- overflow  output  1  signed overflow, equal to (borrow into MSB) XOR (borrow out of MSB).

Behaviour:
- Reset (rst high at an edge, in any state): state=IDLE and all of the following clear to 0: shift_a, shift_b, diff, borrow, bit_cnt, borrow_out, overflow. busy=0, done=0.
- The FSM has three states:
  - IDLE:
    - If start=1, load shift_a<=a_data, shift_b<=b_data, diff<=0, borrow<=0, bit_cnt<=0 and go to SHIFT.
    - If start=0, hold; diff and the flags keep their last values.
  - SHIFT: every cycle, with a0=shift_a[0], b0=shift_b[0], bin=borrow:
    - d = a0^b0^bin; bout = (~a0&b0) | (~(a0^b0)&bin).
    - diff <= {d, diff[WIDTH-1:1]}, a right shift that inserts d at the MSB.
    - shift_a and shift_b logical-shift right by 1, zero fill.
    - borrow <= bout; bit_cnt <= bit_cnt+1.
    - When bit_cnt==WIDTH-1 (processing the MSB): borrow_out<=bout, overflow<=bin^bout, go to DONE.
  - DONE:
    - done=1 for exactly this cycle; busy=1.
    - Next state is always IDLE.
- Latency:
  - start is accepted at edge E0.
  - Bits 0..WIDTH-1 are processed at edges E1..EWIDTH.
  - done is high in the cycle following EWIDTH, i.e. WIDTH+1 cycles after acceptance.
  - The earliest next acceptance is one cycle after done.
- Handshake: start is level-sampled in IDLE only. start during SHIFT or DONE is ignored and not queued. Operand inputs only need to be stable at the accepting edge.
- Output stability:
  - diff is updated only in SHIFT, so it shows partial results while busy=1.
  - Consumers read diff at done or any time after it, until the next acceptance clears it.
  - borrow_out and overflow change only at the MSB step; they keep their old values until that step.
- Width rules:
  - bit_cnt is $clog2(WIDTH) bits and never wraps beyond WIDTH-1.
  - All arithmetic is modulo 2^WIDTH; there is no carry-in port.
- Reset mid-operation: rst overrides every state. The operation is abandoned, no done pulse is issued, and outputs clear the following cycle.
- Simultaneous rst and start: rst wins, and start is not accepted.

Decomposition:
- Package serial_arith_pkg holds:
  - the state enum {IDLE, SHIFT, DONE};
  - the default WIDTH constant, shared with the serial adder;
  - the counter-width helper.
- Sub-module full_subtractor_1bit: inputs a, b, bin; outputs d, bout; purely combinational.
- The top module holds the FSM, the shift registers, the counter and the flags.

Test Plan:
- Reset, then A=0x05, B=0x03 -> done 9 cycles after start; diff=0x02, borrow_out=0, overflow=0.
- A=0x03, B=0x05 -> diff=0xFE, borrow_out=1, overflow=0.
- A=0x80, B=0x01 -> diff=0x7F, borrow_out=0, overflow=1. Then A=0x7F, B=0xFF -> diff=0x80, borrow_out=1, overflow=1.
- Start with A=0x10, B=0x01; pulse start again with A=0xFF, B=0x00 at cycle 3 -> the second start is ignored; diff=0x0F; busy stays high until done drops.
- Start with A=0xAA, B=0x55; assert rst at cycle 4 -> no done pulse; diff=0, busy=0 next cycle. Then start A=0x00, B=0x00 -> diff=0x00, borrow_out=0.
- Back-to-back: assert start in the cycle after done with A=0xFF, B=0xFF -> accepted; diff=0x00, borrow_out=0. Repeat at WIDTH=16 with A=0x0000, B=0x0001 -> diff=0xFFFF, borrow_out=1, done 17 cycles after start.
